sync_fifo: RTL

Parametrised single-clock FIFO that replaces the fixed 32x5 FIFO as the general buffering primitive for the lab designs. It has configurable width and depth, an occupancy count, programmable almost-full and almost-empty thresholds, and sticky-free overflow/underflow error pulses. An optional first-word-fall-through (FWFT) read mode is included. It sits between any producer/consumer pair in the same clock domain, such as a serial-to-parallel front end feeding the sequence detectors or RAM loaders.

---
 rtl/sync_fifo.sv | 112 +++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with an occupancy count,
// programmable almost-full/almost-empty thresholds, one-cycle
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately left out of reset; only pointers and count matter.
  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             overflow_r;
  logic             underflow_r;
  logic [WIDTH-1:0] dout_r;
  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Flag decode from the registered occupancy and request acceptance.
  always_comb begin
    full_s   = (count_r == CW'(DEPTH));
    empty_s  = (count_r == {CW{1'b0}});
    wr_acc_s = wr_en & ~full_s;
    rd_acc_s = rd_en & ~empty_s;
  end

  // Next occupancy: a matched write/read pair leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write port; no reset so contents are simply abandoned on rst.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Pointers, count, error pulses and the registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      dout_r      <= {WIDTH{1'b0}};
    end else begin
      count_r     <= count_nxt_s;
      overflow_r  <= wr_en & full_s;
      underflow_r <= rd_en & empty_s;
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        dout_r   <= mem_r[rd_ptr_r];
      end
    end
  end

  // Output drive: FWFT exposes the head word directly, otherwise the register.
  always_comb begin
    if (FWFT != 0) begin
      if (empty_s) begin
        data_out = {WIDTH{1'b0}};
      end else begin
        data_out = mem_r[rd_ptr_r];
      end
    end else begin
      data_out = dout_r;
    end
    full         = full_s;
    empty        = empty_s;
    almost_full  = (count_r >= CW'(AF_LEVEL));
    almost_empty = (count_r <= CW'(AE_LEVEL));
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule
